axi_lite_slave: RTL

- Memory-backed AXI4-Lite responder: the slave end of the bus the interconnect masters drive.
- Accepts one read or one write transaction at a time on the five AXI4-Lite channels.
- Stores bytes in an internal array of MEM_DEPTH entries and returns OKAY, or DECERR for out-of-range addresses.
- Serves as the DUT/target for master-side and interconnect verification; the scoreboard mirrors its buffer.

---
 rtl/axi_lite_if.sv | 35 +++
 rtl/axi_lite_slave.sv | 129 ++++++++++++
 2 files changed

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle: the five channels between one master and one slave.
// The master modport drives address/data/valid; the slave modport drives ready/response.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;

  modport master (
    output ar_addr, ar_valid, r_ready, aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
    input  ar_ready, r_data, r_resp, r_valid, aw_ready, w_ready, b_resp, b_valid
  );

  modport slave (
    input  ar_addr, ar_valid, r_ready, aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
    output ar_ready, r_data, r_resp, r_valid, aw_ready, w_ready, b_resp, b_valid
  );
endinterface

// File: rtl/axi_lite_slave.sv
// Memory-backed AXI4-Lite slave: one read or write at a time, OKAY in range, DECERR beyond MEM_DEPTH.
// Moore FSM with registered channel outputs; memory is a plain array with a registered read port.
module axi_lite_slave #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_DEPTH  = 4096
) (
  input logic       aclk,
  input logic       areset_n,
  axi_lite_if.slave bus
);
  localparam int IDX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP} state_t;

  state_t                state_reg;
  logic                  last_was_read_reg;
  logic                  ar_ready_reg;
  logic                  r_valid_reg;
  logic [1:0]            r_resp_reg;
  logic                  aw_ready_reg;
  logic                  w_ready_reg;
  logic                  b_valid_reg;
  logic [1:0]            b_resp_reg;
  logic                  w_in_range_reg;
  logic [IDX_WIDTH-1:0]  w_idx_reg;
  logic [DATA_WIDTH-1:0] rd_data_reg;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Upper address bits only take part in this check; the index itself is never wrapped.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < DEPTH_LIMIT;
  endfunction

  // Memory has no reset, so a committed write survives a later areset_n pulse.
  always_ff @(posedge aclk) begin
    if (state_reg == RADDR) begin
      rd_data_reg <= mem[bus.ar_addr[IDX_WIDTH-1:0]];
    end
    if (state_reg == WDATA && bus.w_valid && w_in_range_reg) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (bus.w_strb[i]) begin
          mem[w_idx_reg][i*8 +: 8] <= bus.w_data[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_reg         <= IDLE;
      last_was_read_reg <= 1'b0;
      ar_ready_reg      <= 1'b0;
      r_valid_reg       <= 1'b0;
      r_resp_reg        <= RESP_OKAY;
      aw_ready_reg      <= 1'b0;
      w_ready_reg       <= 1'b0;
      b_valid_reg       <= 1'b0;
      b_resp_reg        <= RESP_OKAY;
      w_in_range_reg    <= 1'b0;
      w_idx_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // When both request, alternate so neither direction can starve the other.
          if (bus.ar_valid && (!bus.aw_valid || !last_was_read_reg)) begin
            state_reg    <= RADDR;
            ar_ready_reg <= 1'b1;
          end else if (bus.aw_valid) begin
            state_reg    <= WADDR;
            aw_ready_reg <= 1'b1;
          end
        end
        RADDR: begin
          ar_ready_reg <= 1'b0;
          r_valid_reg  <= 1'b1;
          r_resp_reg   <= addr_in_range(bus.ar_addr) ? RESP_OKAY : RESP_DECERR;
          state_reg    <= RDATA;
        end
        RDATA: begin
          if (bus.r_ready) begin
            r_valid_reg       <= 1'b0;
            r_resp_reg        <= RESP_OKAY;
            last_was_read_reg <= 1'b1;
            state_reg         <= IDLE;
          end
        end
        WADDR: begin
          aw_ready_reg   <= 1'b0;
          w_ready_reg    <= 1'b1;
          w_idx_reg      <= bus.aw_addr[IDX_WIDTH-1:0];
          w_in_range_reg <= addr_in_range(bus.aw_addr);
          state_reg      <= WDATA;
        end
        WDATA: begin
          if (bus.w_valid) begin
            w_ready_reg <= 1'b0;
            b_valid_reg <= 1'b1;
            b_resp_reg  <= w_in_range_reg ? RESP_OKAY : RESP_DECERR;
            state_reg   <= WRESP;
          end
        end
        WRESP: begin
          if (bus.b_ready) begin
            b_valid_reg       <= 1'b0;
            b_resp_reg        <= RESP_OKAY;
            last_was_read_reg <= 1'b0;
            state_reg         <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ar_ready = ar_ready_reg;
  assign bus.r_valid  = r_valid_reg;
  assign bus.r_resp   = r_resp_reg;
  // Read data is forced to zero outside a valid OKAY beat, including DECERR and reset.
  assign bus.r_data   = (r_valid_reg && r_resp_reg == RESP_OKAY) ? rd_data_reg : '0;
  assign bus.aw_ready = aw_ready_reg;
  assign bus.w_ready  = w_ready_reg;
  assign bus.b_valid  = b_valid_reg;
  assign bus.b_resp   = b_resp_reg;
endmodule
